serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder built around the team's single-bit full-adder stage.
- Owns the operand shift registers, bit counter, carry flip-flop and start/done handshake that feed the full-adder one bit per clock and collect its s/c_out outputs.
- Trades latency for area in datapaths where a WIDTH-bit ripple adder is too large.
- Sits between an operand-producing master (issues start) and a result consumer (samples on done).

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- c_in  input  1  carry-in; captured only on an accepted start.
- busy  output  1  high while an addition is in progress (state RUN).
- done  output  1  one-cycle pulse: sum and c_out are valid.
- sum  output  WIDTH  registered result; held stable until the next accepted start completes.
- c_out  output  1  registered carry-out; held like sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, c_out=0, counter=0, carry flop=0, shift registers=0. Reset low mid-RUN aborts the operation; no done is produced.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Start acceptance: start=1 at a rising edge while in IDLE or DONE. On acceptance:
  - a and b load into shift registers A/B.
  - carry flop loads c_in.
  - counter loads 0.
  - next state is RUN.
- start while in RUN is ignored, with no effect on state or operands.
- RUN, each rising edge:
  - bit s = A[0]^B[0]^carry.
  - carry <= (carry&(A[0]^B[0]))|(A[0]&B[0]).
  - A and B shift right by 1.
  - s shifts into the MSB of an internal result register, which shifts right.
  - counter increments.
- Exit from RUN: at the edge where counter==WIDTH-1 (the WIDTH-th RUN edge):
  - the final bit is processed.
  - sum <= completed result register.
  - c_out <= final carry.
  - next state is DONE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after E0. Throughput is one result per WIDTH+1 cycles; back-to-back operation is achieved by asserting start during DONE.
- DONE → RUN if start=1, else → IDLE.
- sum/c_out change only at the RUN→DONE edge and at reset; they are never changed by start alone.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1), computed exactly with no saturation.
- Counter width is clog2(WIDTH) bits, minimum 1. For WIDTH=1, RUN lasts exactly one edge.
- a, b and c_in may change freely after the accepting edge; internal copies are used.
- Simultaneous reset and start: reset wins.

Test Plan:
- WIDTH=8; a=8'h0F, b=8'h01, c_in=0, start pulse at E0 → busy high for E1..E8; done high only in the cycle after E8; sum=8'h10, c_out=0.
- a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, c_out=1. Then a=8'hFF, b=8'hFF, c_in=1 → sum=8'hFF, c_out=1.
- Mid-operation start: start a=8'h12, b=8'h34; at E3 assert start with a=8'hAA, b=8'h55 → ignored; result sum=8'h46, c_out=0; done asserted once.
- Back-to-back: start held high during the DONE cycle with a=8'h80, b=8'h80, c_in=0 → first result is delivered, the next done follows 9 cycles later with sum=8'h00, c_out=1; sum holds its prior value until then.
- Reset mid-RUN: deassert rst_n asynchronously between E4 and E5 → busy, done, sum and c_out are 0 immediately; after release the block stays IDLE with no done until the next start.
- Random regression, WIDTH=1 and WIDTH=32: at least 1000 random a, b, c_in values → {c_out,sum} equals the reference a+b+c_in; done spacing is exactly WIDTH+1 cycles.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake/operand bundle between an operand master and the serial adder.
// Latency: none; this file only groups signals.
// Backpressure: master may raise start at any time; the adder ignores it while busy.
// Ports (master view): start, a, b, c_in out; busy, done, sum, c_out in.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: {c_out,sum} = a + b + c_in using one full-adder stage.
// Latency: done pulses in the cycle after the WIDTH-th RUN edge following the start edge.
// Backpressure: start is ignored while busy; holding start during done chains the next add.
// Ports: clk, rst_n (async active-low), bus (serial_adder_if.slave: start/a/b/c_in in,
//        busy/done/sum/c_out out; sum and c_out hold until the next add completes).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-adder stage and the result register after absorbing this cycle's bit.
  logic             bit_s;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (carry_q & (a_q[0] ^ b_q[0])) | (a_q[0] & b_q[0]);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    res_shift = (res_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;

    case (state_q)
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish the result only here, so sum/c_out stay stable through the next add.
          sum_d   = res_shift;
          c_out_d = carry_nxt;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 scenarios plus random
// regressions at WIDTH=1 and WIDTH=32 against an arithmetic reference a+b+c_in.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.c_in  = ci;
    tick();
    if8.start = 1'b0;
    // Operands are free to change once accepted.
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    if8.c_in  = 1'($urandom);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (if8.done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("w8_done_seen", 64'(if8.done), 64'(1));
  endtask

  task automatic ld32(output longint e);
    logic [31:0] a, b;
    logic        ci;
    a = $urandom;
    b = $urandom;
    ci = 1'($urandom_range(0, 1));
    if32.start = 1'b1;
    if32.a     = a;
    if32.b     = b;
    if32.c_in  = ci;
    e = longint'(a) + longint'(b) + longint'(ci);
  endtask

  task automatic ld1(output longint e);
    logic a, b, ci;
    a  = 1'($urandom_range(0, 1));
    b  = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    if1.start = 1'b1;
    if1.a     = a;
    if1.b     = b;
    if1.c_in  = ci;
    e = longint'(a) + longint'(b) + longint'(ci);
  endtask

  task automatic rand32(input int nops);
    longint e;
    int     n;
    int     last;
    last = 0;
    ld32(e);
    tick();
    for (int i = 0; i < nops; i++) begin
      if32.start = 1'b0;
      if32.a     = $urandom;
      if32.b     = $urandom;
      n = 0;
      while (if32.done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("r32_latency", 64'(n), 64'(32));
      chk("r32_result", 64'({if32.c_out, if32.sum}), 64'(e));
      if (i > 0) chk("r32_spacing", 64'(cyc - last), 64'(33));
      last = cyc;
      if (i < nops - 1) begin
        ld32(e);
        tick();
      end
    end
    if32.start = 1'b0;
    tick();
  endtask

  task automatic rand1(input int nops);
    longint e;
    int     n;
    int     last;
    last = 0;
    ld1(e);
    tick();
    for (int i = 0; i < nops; i++) begin
      if1.start = 1'b0;
      if1.a     = 1'($urandom);
      if1.b     = 1'($urandom);
      n = 0;
      while (if1.done !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("r1_latency", 64'(n), 64'(1));
      chk("r1_result", 64'({if1.c_out, if1.sum}), 64'(e));
      if (i > 0) chk("r1_spacing", 64'(cyc - last), 64'(2));
      last = cyc;
      if (i < nops - 1) begin
        ld1(e);
        tick();
      end
    end
    if1.start = 1'b0;
    tick();
  endtask

  initial begin
    int  n;
    bit  ok;

    if8.start = 0; if8.a = 0; if8.b = 0; if8.c_in = 0;
    if1.start = 0; if1.a = 0; if1.b = 0; if1.c_in = 0;
    if32.start = 0; if32.a = 0; if32.b = 0; if32.c_in = 0;

    // Reset state
    rst_n = 1'b0;
    #22;
    chk("rst_busy", 64'(if8.busy), 64'(0));
    chk("rst_done", 64'(if8.done), 64'(0));
    chk("rst_sum", 64'(if8.sum), 64'(0));
    chk("rst_cout", 64'(if8.c_out), 64'(0));
    rst_n = 1'b1;
    tick();
    tick();

    // 0F + 01: busy across E1..E8, done only after E8
    go8(8'h0F, 8'h01, 1'b0);
    chk("t1_busy_e0", 64'(if8.busy), 64'(1));
    ok = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (if8.busy !== 1'b1 || if8.done !== 1'b0) ok = 1'b0;
    end
    chk("t1_busy_run", 64'(ok), 64'(1));
    tick();
    chk("t1_done", 64'(if8.done), 64'(1));
    chk("t1_busy_off", 64'(if8.busy), 64'(0));
    chk("t1_sum", 64'(if8.sum), 64'(8'h10));
    chk("t1_cout", 64'(if8.c_out), 64'(0));
    tick();
    chk("t1_done_pulse", 64'(if8.done), 64'(0));
    tick();
    chk("t1_sum_hold", 64'(if8.sum), 64'(8'h10));

    // Carry-out boundaries
    go8(8'hFF, 8'h01, 1'b0);
    wait_done8(n);
    chk("t2_latency", 64'(n), 64'(8));
    chk("t2_res", 64'({if8.c_out, if8.sum}), 64'(9'h100));
    tick();
    go8(8'hFF, 8'hFF, 1'b1);
    wait_done8(n);
    chk("t3_res", 64'({if8.c_out, if8.sum}), 64'(9'h1FF));
    tick();

    // Start during RUN is ignored
    go8(8'h12, 8'h34, 1'b0);
    chk("t4_sum_prior", 64'(if8.sum), 64'(8'hFF));
    tick();
    tick();
    if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
    tick();
    if8.start = 1'b0;
    chk("t4_busy", 64'(if8.busy), 64'(1));
    wait_done8(n);
    chk("t4_latency", 64'(n), 64'(5));
    chk("t4_res", 64'({if8.c_out, if8.sum}), 64'(9'h046));
    tick();
    chk("t4_single_done", 64'(if8.done), 64'(0));
    chk("t4_idle", 64'(if8.busy), 64'(0));

    // Back-to-back via start held during DONE
    go8(8'h11, 8'h22, 1'b0);
    wait_done8(n);
    chk("t5_first", 64'({if8.c_out, if8.sum}), 64'(9'h033));
    if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h80; if8.c_in = 1'b0;
    tick();
    if8.start = 1'b0;
    chk("t5_rerun", 64'(if8.busy), 64'(1));
    n = 1;
    ok = 1'b1;
    while (if8.done !== 1'b1 && n < 30) begin
      if (if8.sum !== 8'h33) ok = 1'b0;
      tick();
      n++;
    end
    chk("t5_sum_hold", 64'(ok), 64'(1));
    chk("t5_spacing", 64'(n), 64'(9));
    chk("t5_second", 64'({if8.c_out, if8.sum}), 64'(9'h100));
    tick();

    // Asynchronous reset in the middle of RUN
    go8(8'h30, 8'h0C, 1'b0);
    wait_done8(n);
    chk("t6_pre", 64'({if8.c_out, if8.sum}), 64'(9'h03C));
    tick();
    go8(8'h01, 8'h02, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(if8.busy), 64'(0));
    chk("t6_rst_done", 64'(if8.done), 64'(0));
    chk("t6_rst_sum", 64'(if8.sum), 64'(0));
    #3 rst_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if8.done !== 1'b0 || if8.busy !== 1'b0) ok = 1'b0;
    end
    chk("t6_stays_idle", 64'(ok), 64'(1));
    go8(8'h07, 8'h09, 1'b1);
    wait_done8(n);
    chk("t6_after_rst", 64'({if8.c_out, if8.sum}), 64'(9'h011));
    tick();

    // Random regressions at the width extremes
    rand1(1000);
    rand32(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
